// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   localparam int unsigned DMEM_DEPTH = 256;
   localparam int unsigned DMEM_IDX_W = $clog2(DMEM_DEPTH);

   function automatic arb_state_e own_state(input logic id);
      return (id == PORT_LDR) ? StOwn1 : StOwn0;
   endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Combinational grant select: fixed m0 priority from idle, owner keeps the bus up to the burst cap.
module dmem_arb_prio
   import dmem_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  arb_state_e       state,
   input  logic [CNT_W-1:0] burst_cnt,
   input  logic             m0_req,
   input  logic             m1_req,
   output logic [1:0]       gnt,
   output logic             owner
);

   logic cap_ok;

   assign cap_ok = burst_cnt < CNT_W'(MAX_BURST);

   always_comb begin
      gnt = 2'b00;
      case (state)
         StIdle: begin
            if (m0_req)      gnt = 2'b01;
            else if (m1_req) gnt = 2'b10;
         end
         StOwn0: begin
            if (m0_req && (cap_ok || !m1_req)) gnt = 2'b01;
            else if (m1_req)                   gnt = 2'b10;
         end
         StOwn1: begin
            if (m1_req && (cap_ok || !m0_req)) gnt = 2'b10;
            else if (m0_req)                   gnt = 2'b01;
         end
         default: gnt = 2'b00;
      endcase
   end

   assign owner = gnt[1] ? PORT_LDR : PORT_CPU;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous-read data memory.
// Optional address checking is enabled with DMEM_ARB_ADDR_CHECK_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned DEPTH     = DMEM_DEPTH,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              m1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_tag_q, rd_tag_d;
   logic [1:0]        gnt;
   logic              owner, any_gnt, win_we, illegal, rd_ill;
   logic [ADDR_W-1:0] win_addr;
   logic [31:0]       win_wdata;

   dmem_arb_prio #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_prio (
      .state     (state_q),
      .burst_cnt (burst_cnt_q),
      .m0_req    (m0_req),
      .m1_req    (m1_req),
      .gnt       (gnt),
      .owner     (owner)
   );

   assign m0_gnt  = gnt[0];
   assign m1_gnt  = gnt[1];
   assign any_gnt = |gnt;

   assign win_we    = (owner == PORT_LDR) ? m1_we    : m0_we;
   assign win_addr  = (owner == PORT_LDR) ? m1_addr  : m0_addr;
   assign win_wdata = (owner == PORT_LDR) ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
   logic err_q, ill_q;

   assign illegal = (win_addr[1:0] != 2'b00) ||
                    ({2'b00, win_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
   assign rd_ill  = ill_q;
   assign m0_err  = err_q && (rd_tag_q == PORT_CPU);
   assign m1_err  = err_q && (rd_tag_q == PORT_LDR);
`else
   assign illegal = 1'b0;
   assign rd_ill  = 1'b0;
   assign m0_err  = 1'b0;
   assign m1_err  = 1'b0;
`endif

   // Illegal accesses are still granted but never reach the memory.
   always_comb begin
      mem_addr  = any_gnt ? win_addr  : '0;
      mem_wdata = any_gnt ? win_wdata : '0;
      mem_read  = any_gnt && !win_we && !illegal;
      mem_write = any_gnt &&  win_we && !illegal;
   end

   always_comb begin
      state_d     = any_gnt ? own_state(owner) : StIdle;
      rd_pend_d   = any_gnt && !win_we;
      rd_tag_d    = any_gnt ? owner : rd_tag_q;
      burst_cnt_d = '0;
      if (any_gnt) begin
         if (state_q == own_state(owner)) begin
            burst_cnt_d = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                             : burst_cnt_q + 1'b1;
         end else begin
            burst_cnt_d = CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         burst_cnt_q <= '0;
         rd_pend_q   <= 1'b0;
         rd_tag_q    <= PORT_CPU;
`ifdef DMEM_ARB_ADDR_CHECK_EN
         err_q       <= 1'b0;
         ill_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rd_tag_q    <= rd_tag_d;
`ifdef DMEM_ARB_ADDR_CHECK_EN
         err_q       <= any_gnt && illegal;
         ill_q       <= any_gnt && illegal;
`endif
      end
   end

   assign m0_rvalid = rd_pend_q && (rd_tag_q == PORT_CPU);
   assign m1_rvalid = rd_pend_q && (rd_tag_q == PORT_LDR);
   assign m0_rdata  = (m0_rvalid && !rd_ill) ? mem_rdata : 32'h0;
   assign m1_rdata  = (m1_rvalid && !rd_ill) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural synchronous-read memory.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_BURST(4), .DEPTH(256), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m0_err    (m0_err),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .m1_err    (m1_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata)
   );

   // Memory model: write and registered read on the same edge
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
   end

   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [256];
   int          checks = 0;
   int          errors = 0;

   function automatic logic is_illegal(input logic [31:0] a);
`ifdef DMEM_ARB_ADDR_CHECK_EN
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
`else
      return 1'b0;
`endif
   endfunction

   // Scoreboard: reads push the reference value at grant, returns pop and compare
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (m0_rvalid || m1_rvalid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_return: rvalid m0=%0b m1=%0b but no read outstanding",
                        m0_rvalid, m1_rvalid);
            end else begin
               e = sb.pop_front();
               if ((m0_rvalid && m1_rvalid) || (m1_rvalid !== e.port) ||
                   ((e.port ? m1_rdata : m0_rdata) !== e.data)) begin
                  errors++;
                  $display("FAIL sb_return: got m0v=%0b m1v=%0b d0=%h d1=%h, want port %0d data %h",
                           m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, e.port, e.data);
               end
            end
         end
         checks++;
         if ((m0_gnt && m1_gnt) || (m0_gnt && !m0_req) || (m1_gnt && !m1_req)) begin
            errors++;
            $display("FAIL gnt_sanity: gnt=%0b%0b req=%0b%0b, want one-hot gnt within req",
                     m1_gnt, m0_gnt, m1_req, m0_req);
         end
         if (m0_gnt) begin
            if (m0_we) begin
               if (!is_illegal(m0_addr)) ref_mem[m0_addr[9:2]] = m0_wdata;
            end else begin
               sb.push_back({PORT_CPU, is_illegal(m0_addr) ? 32'h0 : ref_mem[m0_addr[9:2]]});
            end
         end
         if (m1_gnt) begin
            if (m1_we) begin
               if (!is_illegal(m1_addr)) ref_mem[m1_addr[9:2]] = m1_wdata;
            end else begin
               sb.push_back({PORT_LDR, is_illegal(m1_addr) ? 32'h0 : ref_mem[m1_addr[9:2]]});
            end
         end
      end
   end

   task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write} !== 8'h0)
      begin
         errors++;
         $display("FAIL reset_ctrl: got %b, want 00000000",
                  {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write});
      end
      checks++;
      if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h, want all 0",
                  mem_addr, mem_wdata, m0_rdata, m1_rdata);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      @(posedge clk); #1 drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1 || mem_read !== 1'b1) begin
         errors++;
         $display("FAIL rmr_grant: gnt=%0b mem_read=%0b, want 1 1", m0_gnt, mem_read);
      end
      #2 rst = 1'b1; drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      checks++;
      if (m0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rmr_rvalid: got %0b, want 0", m0_rvalid);
      end
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (dut.state_q !== StIdle || m0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rmr_release: state=%0d rvalid=%0b, want IDLE 0", dut.state_q, m0_rvalid);
      end
   endtask

   task automatic test_single_read();
      @(posedge clk); #1 drive_m1(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (m1_gnt !== 1'b1 || mem_write !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL preload: gnt=%0b we=%0b wdata=%h, want 1 1 deadbeef",
                  m1_gnt, mem_write, mem_wdata);
      end
      @(posedge clk); #1 drive_m1(1'b0, 1'b0, 32'h0, 32'h0); drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL read_cmd: gnt=%0b rd=%0b addr=%h, want 1 1 10", m0_gnt, mem_read, mem_addr);
      end
      @(posedge clk); #1 drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL read_ret: v0=%0b d0=%h v1=%0b, want 1 deadbeef 0",
                  m0_rvalid, m0_rdata, m1_rvalid);
      end
   endtask

   task automatic test_write_read();
      @(posedge clk); #1 drive_m1(1'b1, 1'b1, 32'h20, 32'h0000_1234);
      @(posedge clk); #1 drive_m1(1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      checks++;
      if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd_cmd: gnt=%0b rvalid=%0b, want 1 0", m1_gnt, m1_rvalid);
      end
      @(posedge clk); #1 drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0000_1234) begin
         errors++;
         $display("FAIL wr_rd_ret: v=%0b d=%h, want 1 00001234", m1_rvalid, m1_rdata);
      end
   endtask

   task automatic test_contention();
      int k0 = 0;
      int k1 = 0;
      for (int i = 0; i < 12; i++) begin
         logic want;
         want = ((i / 4) % 2) == 1;
         @(posedge clk); #1;
         drive_m0(1'b1, 1'b1, 32'h100 + 32'(4 * k0), 32'hA000_0000 + 32'(k0));
         drive_m1(1'b1, 1'b1, 32'h200 + 32'(4 * k1), 32'hB000_0000 + 32'(k1));
         @(negedge clk);
         checks++;
         if ((m0_gnt ^ m1_gnt) !== 1'b1 || m1_gnt !== want) begin
            errors++;
            $display("FAIL contention[%0d]: gnt=%0b%0b, want port %0d", i, m1_gnt, m0_gnt, want);
         end
         if (m0_gnt) k0++;
         if (m1_gnt) k1++;
      end
      @(posedge clk); #1 drive_m0(1'b0, 1'b0, 32'h0, 32'h0); drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j <= 4; j++) begin
         @(posedge clk); #1;
         if (j < 4) drive_m0(1'b1, 1'b0, 32'h100 + 32'(4 * j), 32'h0);
         else       drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         if (j < 4) begin
            checks++;
            if (m0_gnt !== 1'b1) begin
               errors++;
               $display("FAIL b2b_gnt[%0d]: got %0b, want 1", j, m0_gnt);
            end
         end
         if (j > 0) begin
            checks++;
            if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0000 + 32'(j - 1)) begin
               errors++;
               $display("FAIL b2b_data[%0d]: v=%0b d=%h, want 1 %h", j, m0_rvalid, m0_rdata,
                        32'hA000_0000 + 32'(j - 1));
            end
         end
      end
   endtask

   task automatic test_owner_release();
      @(posedge clk); #1 drive_m1(1'b1, 1'b1, 32'h300, 32'h5555_0000);
      @(posedge clk); #1 drive_m1(1'b1, 1'b1, 32'h300, 32'h5555_0001);
      @(posedge clk); #1 drive_m1(1'b0, 1'b0, 32'h0, 32'h0); drive_m0(1'b1, 1'b1, 32'h304, 32'h77);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL release_gnt: gnt=%0b%0b, want 01", m1_gnt, m0_gnt);
      end
      @(posedge clk); #1 drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (dut.burst_cnt_q !== 3'd1 || dut.state_q !== StOwn0) begin
         errors++;
         $display("FAIL release_cnt: cnt=%0d state=%0d, want 1 OWN0",
                  dut.burst_cnt_q, dut.state_q);
      end
   endtask

   task automatic test_addr_check();
`ifdef DMEM_ARB_ADDR_CHECK_EN
      @(posedge clk); #1 drive_m0(1'b1, 1'b0, 32'h401, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL ac_unaligned: gnt=%0b rd=%0b, want 1 0", m0_gnt, mem_read);
      end
      @(posedge clk); #1 drive_m0(1'b1, 1'b0, 32'h400, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1 || mem_read !== 1'b0 || m0_err !== 1'b1 || m0_rvalid !== 1'b1 ||
          m0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL ac_range: gnt=%0b rd=%0b err=%0b v=%0b d=%h, want 1 0 1 1 0",
                  m0_gnt, mem_read, m0_err, m0_rvalid, m0_rdata);
      end
      @(posedge clk); #1 drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_err !== 1'b1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'h0 || m1_err !== 1'b0) begin
         errors++;
         $display("FAIL ac_ret: err=%0b v=%0b d=%h err1=%0b, want 1 1 0 0",
                  m0_err, m0_rvalid, m0_rdata, m1_err);
      end
`else
      @(posedge clk); #1 drive_m0(1'b1, 1'b0, 32'h400, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h400) begin
         errors++;
         $display("FAIL passthru_cmd: gnt=%0b rd=%0b addr=%h, want 1 1 400",
                  m0_gnt, mem_read, mem_addr);
      end
      @(posedge clk); #1 drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (m0_err !== 1'b0 || m0_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL passthru_ret: err=%0b v=%0b, want 0 1", m0_err, m0_rvalid);
      end
`endif
   endtask

   task automatic test_drain();
      int n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d reads never returned, want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_read();
      test_single_read();
      test_write_read();
      test_contention();
      test_back_to_back();
      test_owner_release();
      test_addr_check();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters.
  - Port m0 is the CPU load/store path.
  - Port m1 is the debug/program loader (DMA-style).
- Sits between both requesters and the data memory, and drives its address, write data, MemRead and MemWrite.
- Read data returns one cycle after grant, matching the memory's registered read.
- Ownership-based arbitration: m0 has fixed priority, and a burst cap prevents starvation of either requester.

Parameters:
- MAX_BURST, 4: maximum consecutive grants to the current owner while the other port is requesting.
- DEPTH, 256: number of 32-bit words in the data memory.
- ADDR_W, 32: byte-address width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- m0_req  input  1  CPU access request; address, data and we held stable until granted
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  ADDR_W  byte address; word index = addr[ADDR_W-1:2]
- m0_wdata  input  32  write data
- m0_gnt  output  1  combinational; the access completes in the cycle where m0_req && m0_gnt
- m0_rvalid  output  1  registered; read data valid, one cycle after a read grant
- m0_rdata  output  32  read data; 0 when m0_rvalid = 0
- m0_err  output  1  address error pulse (see Optional Feature)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0, for the loader
- mem_addr  output  ADDR_W  memory address, muxed from the winner; 0 when idle
- mem_wdata  output  32  memory write data; 0 when idle
- mem_read  output  1  MemRead strobe
- mem_write  output  1  MemWrite strobe
- mem_rdata  input  32  memory read data, registered inside the memory

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE, burst_cnt = 0, rd_pend = 0, rd_tag = 0.
  - All outputs 0: gnt, rvalid and err are 0; the mem_* outputs are 0 because no grant exists.
- States: IDLE, OWN0, OWN1.
- Grant selection (combinational, evaluated every cycle):
  - IDLE: m0_req → grant m0; else m1_req → grant m1; else no grant.
  - OWNx: grant x if mx_req && (burst_cnt < MAX_BURST || !other_req).
    - Else grant the other port if it is requesting.
    - Else no grant.
  - At most one gnt is high per cycle.
  - gnt is never asserted without the matching req.
- State update (posedge clk):
  - next state = OWN of the granted port, or IDLE when nothing is granted.
  - burst_cnt:
    - = 1 on an owner change or when leaving IDLE.
    - = burst_cnt + 1, saturating at MAX_BURST, when the same owner is granted again.
    - = 0 in IDLE.
- Memory command (combinational, from the winner):
  - mem_addr and mem_wdata take the winner's addr and wdata.
  - mem_read = !we, mem_write = we.
  - Both strobes are 0 when nothing is granted.
- Read return:
  - rd_pend <= read granted; rd_tag <= id of the granted port.
  - mx_rvalid = rd_pend && rd_tag == x.
  - mx_rdata = mem_rdata when mx_rvalid, else 0.
- Latency:
  - Write: completes at the grant edge.
  - Read: 1 cycle from grant to rvalid.
  - Back-to-back grants are allowed, giving full throughput (one access per cycle).
- Boundary conditions:
  - Both ports requesting continuously: m0 gets MAX_BURST grants, then m1 gets MAX_BURST grants, alternating.
  - Owner drops req: in the same cycle the other port may be granted (zero bubble).
  - Write then read to the same address on consecutive cycles returns the new data, because the memory is written before the read edge.
  - Reset asserted while a read is pending: the read is discarded and rvalid stays 0.
  - Address index ≥ DEPTH without the macro: passed through unchecked.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- Defined:
  - An access is illegal if addr[1:0] != 0 or addr[ADDR_W-1:2] >= DEPTH.
  - An illegal access is still granted (so the requester does not hang).
  - mem_read and mem_write are forced to 0 for that access.
  - mx_err pulses 1 cycle after the grant.
  - For an illegal read, mx_rvalid = 1 with mx_rdata = 0.
- Undefined: m0_err and m1_err are tied to 0, and all addresses pass through unchecked.

Decomposition:
- Shared package dmem_pkg:
  - State enum: IDLE / OWN0 / OWN1.
  - Port ids: PORT_CPU = 0, PORT_LDR = 1.
  - DMEM_DEPTH = 256 and word-index width.
- One natural sub-module: dmem_arb_prio, the combinational grant-select block.
  - Inputs: state, burst_cnt, m0_req, m1_req.
  - Outputs: gnt vector, next-owner id.
- The top level keeps the registers, the command mux and the read return path.

Test Plan:
- Reset mid-read: m0 read granted at addr 0x10, rst pulsed before the next edge → m0_rvalid stays 0 and state is IDLE after release.
- Single read: preload word 4 = 0xDEADBEEF, m0 read addr 0x10 → m0_gnt same cycle, next cycle m0_rvalid = 1 and m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
- Write then read: m1 write 0x0000_1234 at addr 0x20, then m1 read 0x20 next cycle → rvalid 2 cycles after the write with data 0x1234.
- Contention: m0 and m1 requesting continuously with MAX_BURST = 4 → grant sequence 0,0,0,0,1,1,1,1,0…; never both gnt high.
- Owner release: m1 owner, m1_req drops while m0_req is high → m0_gnt in the same cycle, burst_cnt = 1.
- DMEM_ARB_ADDR_CHECK_EN: m0 read at addr 0x401 and at 0x400 (index 256) → mem_read = 0, m0_err pulses, m0_rvalid = 1 with m0_rdata = 0.
